edge_skew_feeder: RTL and testbench
===================================

// Module: edge_skew_feeder
// PURPOSE
//  Holds one NxN operand tile written by the host, then streams it into one systolic-array
//  edge as a diagonal wavefront: lane i is delayed by i cycles. One instance drives the row
//  edge in row mode and a second drives the column edge in column mode.
//  Sits between the host tile-load path and the PE grid edge inputs; it is the edge feeder stage.
// PARAMETERS
//  N    8   array dimension (lanes per edge, tile is NxN); power of two
//  DW   16  data width per element
//  AW   6   load address width = 2*log2(N); ADDR[AW-1:AW/2]=row, ADDR[AW/2-1:0]=col
// PORTS
//  CLK         in   1        clock, all logic on posedge
//  RST_N       in   1        synchronous reset, active low
//  LOAD_EN     in   1        write LOAD_DATA into tile[row][col] this edge
//  LOAD_ADDR   in   AW       element index {row,col}
//  LOAD_DATA   in   DW       element value
//  START       in   1        request a stream of the loaded tile
//  COL_MODE    in   1        sampled at START accept: 0=row mode, 1=column mode
//  HOLD        in   1        downstream back-pressure; freezes the stream
//  EDGE_OUT    out  N x DW   per-lane element presented to the array edge (unpacked [0:N-1])
//  EDGE_VALID  out  N        per-lane valid
//  READY       out  1        all N*N entries written since last clear
//  BUSY        out  1        high in RUN
//  DONE        out  1        one-cycle pulse at stream completion
//  ERR         out  1        one-cycle pulse on a rejected START
// BEHAVIOUR
//  Reset (RST_N low at posedge)
//   - State goes to IDLE. Written-bitmap clears.
//   - EDGE_OUT, EDGE_VALID, READY, BUSY, DONE and ERR all go to 0.
//   - Tile contents are undefined after reset.
//  Outputs are registered. Reset mid-RUN aborts the stream; the tile must be fully reloaded.
//  States: IDLE, RUN. Step counter s counts 0..2N-2.
//  IDLE
//   - LOAD_EN writes tile[row][col] and sets bit {row,col} of the 64-bit written-bitmap.
//   - Rewriting an entry overwrites it; the bitmap bit stays set.
//   - READY = &bitmap, registered: high the cycle after the last missing entry is written.
//   - START & READY: accepted. Latch COL_MODE, s<=0, go to RUN.
//   - START & !READY: ERR pulses for 1 cycle; stay in IDLE.
//   - START & LOAD_EN in the same cycle: the write completes, and READY is evaluated before that write.
//  RUN
//   - BUSY=1. LOAD_EN is ignored (no write, bitmap unchanged). START is ignored, with no ERR.
//   - Step s is presented the cycle after the edge that entered it; step 0 is visible
//     the cycle after START accept.
//   - For each lane i at step s, k=s-i:
//       EDGE_VALID[i] = (0<=k<N).
//       EDGE_OUT[i] = row mode ? tile[i][k] : tile[k][i] when valid, else 0.
//   - At each posedge with HOLD=0: s advances. With HOLD=1: s, EDGE_OUT and EDGE_VALID hold.
//   - Posedge with HOLD=0 while s=2N-2:
//       go to IDLE; EDGE_OUT and EDGE_VALID go to 0; DONE pulses next cycle.
//       The bitmap clears, so READY drops; a new tile must be loaded.
//   - Uninterrupted stream = 2N-1 presented cycles (15 for N=8).
//     START accept to DONE = 2N cycles plus held cycles.
//  Widths: data passes through unchanged, no arithmetic. s uses $clog2(2N-1) bits with no wrap.
// TESTING
//  1. Reset with RST_N=0 for 2 cycles.
//     -> all outputs 0, BUSY=0, READY=0. START with no load -> ERR pulses once, BUSY stays 0.
//  2. Load tile[r][c]=8r+c (64 writes), row mode, START with HOLD=0.
//     -> step 0: lane0=0 valid, lanes1-7 invalid.
//     -> step 7: lane i = 8i+7-i, all valid.
//     -> step 14: lane7=63 only. DONE pulses 16 cycles after accept.
//  3. Same tile, column mode. -> step 3: lane0=24, lane1=17, lane2=10, lane3=3, lanes4-7 invalid/0.
//  4. HOLD=1 for 3 cycles at step 5.
//     -> outputs frozen at step-5 values; DONE is delayed by exactly 3 cycles.
//  5. LOAD_EN to addr 0 with data 0xFFFF during RUN.
//     -> streamed lane0 values unchanged; after DONE READY=0.
//     -> load 63 entries -> READY stays 0 until the 64th write.
//  6. RST_N=0 at step 6.
//     -> next cycle: outputs 0, BUSY=0, READY=0. START then gives ERR.

Source files
------------

// File: rtl/edge_skew_feeder.sv
// edge_skew_feeder: buffers one NxN operand tile and replays it onto a systolic-array
// edge as a diagonal wavefront, lane i lagging lane 0 by i cycles (row or column mode).
module edge_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int AW = 2 * $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          start_i,
  input  logic          col_mode_i,
  input  logic          hold_i,
  output logic [DW-1:0] edge_out_o [0:N-1],
  output logic [N-1:0]  edge_valid_o,
  output logic          ready_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int LW = AW / 2;
  localparam int NN = N * N;
  localparam int SW = $clog2(2 * N - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * N - 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  step_q, step_d;
  logic           colMode_q, colMode_d;
  logic [NN-1:0]  written_q, written_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic           doneStage_q, doneStage_d;
  logic           done_q, done_d;
  logic [DW-1:0]  edgeOut_q [0:N-1];
  logic [DW-1:0]  edgeOut_d [0:N-1];
  logic [N-1:0]   edgeValid_q, edgeValid_d;

  logic [DW-1:0]  tile_q [N][N];

  logic           wrEn;
  logic [LW-1:0]  wrRow, wrCol;
  logic           present;
  logic           clearOut;
  logic [DW-1:0]  laneData [0:N-1];
  logic [N-1:0]   laneValid;
  logic [LW-1:0]  rdRow, rdCol;

  assign wrRow = load_addr_i[AW-1:LW];
  assign wrCol = load_addr_i[LW-1:0];

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    colMode_d   = colMode_q;
    written_d   = written_q;
    err_d       = 1'b0;
    doneStage_d = 1'b0;
    done_d      = doneStage_q;
    present     = 1'b0;
    clearOut    = 1'b0;
    wrEn        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en_i) begin
          wrEn                   = 1'b1;
          written_d[load_addr_i] = 1'b1;
        end
        // READY seen here is the registered value, so a same-cycle write cannot enable START
        if (start_i) begin
          if (ready_q) begin
            state_d   = RUN;
            step_d    = '0;
            colMode_d = col_mode_i;
            present   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!hold_i) begin
          if (step_q == LAST_STEP) begin
            state_d     = IDLE;
            written_d   = '0;
            clearOut    = 1'b1;
            doneStage_d = 1'b1;
          end else begin
            step_d  = step_q + SW'(1);
            present = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = &written_d;
  end

  // Lane i shows element k = step - i; a write landing on the accept edge is forwarded
  always_comb begin
    rdRow = '0;
    rdCol = '0;
    for (int i = 0; i < N; i++) begin
      laneValid[i] = 1'b0;
      laneData[i]  = '0;
      if ((int'(step_d) >= i) && (int'(step_d) < i + N)) begin
        laneValid[i] = 1'b1;
        if (colMode_d) begin
          rdRow = LW'(int'(step_d) - i);
          rdCol = LW'(i);
        end else begin
          rdRow = LW'(i);
          rdCol = LW'(int'(step_d) - i);
        end
        if (wrEn && (wrRow == rdRow) && (wrCol == rdCol)) begin
          laneData[i] = load_data_i;
        end else begin
          laneData[i] = tile_q[rdRow][rdCol];
        end
      end
    end
  end

  always_comb begin
    edgeValid_d = edgeValid_q;
    for (int i = 0; i < N; i++) begin
      edgeOut_d[i] = edgeOut_q[i];
    end
    if (clearOut) begin
      edgeValid_d = '0;
      for (int i = 0; i < N; i++) begin
        edgeOut_d[i] = '0;
      end
    end else if (present) begin
      edgeValid_d = laneValid;
      for (int i = 0; i < N; i++) begin
        edgeOut_d[i] = laneData[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      step_q      <= '0;
      colMode_q   <= 1'b0;
      written_q   <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      doneStage_q <= 1'b0;
      done_q      <= 1'b0;
      edgeValid_q <= '0;
      for (int i = 0; i < N; i++) begin
        edgeOut_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      colMode_q   <= colMode_d;
      written_q   <= written_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      doneStage_q <= doneStage_d;
      done_q      <= done_d;
      edgeValid_q <= edgeValid_d;
      for (int i = 0; i < N; i++) begin
        edgeOut_q[i] <= edgeOut_d[i];
      end
    end
  end

  // Tile storage has no reset; a full reload is required before the next stream
  always_ff @(posedge clk_i) begin
    if (rst_ni && wrEn) begin
      tile_q[wrRow][wrCol] <= load_data_i;
    end
  end

  assign edge_out_o   = edgeOut_q;
  assign edge_valid_o = edgeValid_q;
  assign ready_o      = ready_q;
  assign busy_o       = (state_q == RUN);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_edge_skew_feeder.sv
// tb_edge_skew_feeder: directed wavefront tables plus randomized traffic checked
// every cycle against a frame-queue model of the feeder.
module tb_edge_skew_feeder;

   localparam int N     = 8;
   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int STEPS = 2 * N - 1;

   logic          clk = 1'b0;
   logic          rstN;
   logic          loadEn;
   logic [AW-1:0] loadAddr;
   logic [DW-1:0] loadData;
   logic          start;
   logic          colMode;
   logic          hold;
   logic [DW-1:0] edgeOut [0:N-1];
   logic [N-1:0]  edgeValid;
   logic          ready;
   logic          busy;
   logic          done;
   logic          err;

   typedef struct packed {
      logic [N-1:0][DW-1:0] out;
      logic [N-1:0]         valid;
   } frame_t;

   typedef struct {
      logic          cm;
      int            step;
      int            lane;
      logic [DW-1:0] expData;
      logic          expValid;
   } vector_t;

   int passCount  = 0;
   int checkCount = 0;
   int edgeCount  = 0;

   logic [DW-1:0]        mTile [N][N];
   logic [N*N-1:0]       mWritten;
   logic                 mReady;
   logic                 mRun;
   logic                 mDonePend;
   frame_t               frames [$];
   logic [N-1:0][DW-1:0] expOut;
   logic [N-1:0]         expValid;
   logic                 expBusy;
   logic                 expDone;
   logic                 expErr;

   logic [DW-1:0] obsOut   [2][STEPS][N];
   logic          obsValid [2][STEPS][N];

   edge_skew_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .load_en_i    (loadEn),
      .load_addr_i  (loadAddr),
      .load_data_i  (loadData),
      .start_i      (start),
      .col_mode_i   (colMode),
      .hold_i       (hold),
      .edge_out_o   (edgeOut),
      .edge_valid_o (edgeValid),
      .ready_o      (ready),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // The whole stream is precomputed at START accept straight from the wavefront rule
   task automatic buildFrames(input logic cm);
      frame_t f;
      int k;
      frames.delete();
      for (int s = 0; s < STEPS; s++) begin
         f = '0;
         for (int i = 0; i < N; i++) begin
            k = s - i;
            if (k >= 0 && k < N) begin
               f.valid[i] = 1'b1;
               f.out[i]   = cm ? mTile[k][i] : mTile[i][k];
            end
         end
         frames.push_back(f);
      end
   endtask

   task automatic takeFrame();
      frame_t f;
      f        = frames.pop_front();
      expOut   = f.out;
      expValid = f.valid;
   endtask

   // Advances the reference model by one clock edge using the inputs seen at that edge
   task automatic modelEdge();
      logic nextDone, nextErr, wasReady;
      nextDone  = mDonePend;
      mDonePend = 1'b0;
      nextErr   = 1'b0;
      if (!rstN) begin
         mRun     = 1'b0;
         mWritten = '0;
         mReady   = 1'b0;
         expOut   = '0;
         expValid = '0;
         nextDone = 1'b0;
         frames.delete();
      end else if (!mRun) begin
         wasReady = mReady;
         if (loadEn) begin
            mTile[loadAddr[AW-1:AW/2]][loadAddr[AW/2-1:0]] = loadData;
            mWritten[loadAddr] = 1'b1;
         end
         if (start) begin
            if (wasReady) begin
               buildFrames(colMode);
               takeFrame();
               mRun = 1'b1;
            end else begin
               nextErr = 1'b1;
            end
         end
         mReady = ($countones(mWritten) == N * N);
      end else if (!hold) begin
         if (frames.size() == 0) begin
            mRun      = 1'b0;
            mWritten  = '0;
            mReady    = 1'b0;
            expOut    = '0;
            expValid  = '0;
            mDonePend = 1'b1;
         end else begin
            takeFrame();
         end
      end
      expDone = nextDone;
      expErr  = nextErr;
      expBusy = mRun;
   endtask

   task automatic checkOutput();
      logic [N-1:0][DW-1:0] actOut;
      for (int i = 0; i < N; i++) actOut[i] = edgeOut[i];
      checkVal("busy", busy, expBusy);
      checkVal("ready", ready, mReady);
      checkVal("done", done, expDone);
      checkVal("err", err, expErr);
      checkVal("edgeValid", edgeValid, expValid);
      checkVal("edgeOut", actOut, expOut);
   endtask

   // Drives one cycle of inputs, steps the model at the edge, checks 1 time unit later
   task automatic applyStimulus(input logic r, input logic le, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic st, input logic cm,
                                input logic hd);
      rstN = r; loadEn = le; loadAddr = a; loadData = d;
      start = st; colMode = cm; hold = hd;
      @(posedge clk);
      edgeCount++;
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic loadTile(input int count);
      for (int e = 0; e < count; e++) applyStimulus(1, 1, AW'(e), DW'(e), 0, 0, 0);
   endtask

   task automatic capture(input logic cm, input int s);
      for (int i = 0; i < N; i++) begin
         obsOut[cm][s][i]   = edgeOut[i];
         obsValid[cm][s][i] = edgeValid[i];
      end
   endtask

   // Streams the loaded tile, optionally holding after step holdAt, and measures START-to-DONE
   task automatic runStream(input logic cm, input int holdAt, input int holdLen,
                            input logic noiseLoad, output int latency);
      int shown, held, acceptEdge, guard;
      shown = 0; held = 0; guard = 0; latency = -1;
      applyStimulus(1, 0, 0, 0, 1, cm, 0);
      acceptEdge = edgeCount;
      capture(cm, 0);
      while (shown < STEPS - 1) begin
         if (shown == holdAt && held < holdLen) begin
            applyStimulus(1, noiseLoad, 0, 16'hFFFF, noiseLoad, 0, 1);
            held++;
         end else begin
            applyStimulus(1, noiseLoad, 0, 16'hFFFF, noiseLoad, 0, 0);
            shown++;
            capture(cm, shown);
         end
      end
      while (latency < 0 && guard < 8) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         guard++;
         if (done === 1'b1) latency = edgeCount - acceptEdge;
      end
   endtask

   vector_t vectors [16];
   int      latency;

   initial begin
      vectors[0]  = '{1'b0, 0, 0, 16'd0, 1'b1};
      vectors[1]  = '{1'b0, 0, 1, 16'd0, 1'b0};
      vectors[2]  = '{1'b0, 0, 7, 16'd0, 1'b0};
      vectors[3]  = '{1'b0, 7, 0, 16'd7, 1'b1};
      vectors[4]  = '{1'b0, 7, 3, 16'd28, 1'b1};
      vectors[5]  = '{1'b0, 7, 7, 16'd56, 1'b1};
      vectors[6]  = '{1'b0, 14, 7, 16'd63, 1'b1};
      vectors[7]  = '{1'b0, 14, 6, 16'd0, 1'b0};
      vectors[8]  = '{1'b1, 3, 0, 16'd24, 1'b1};
      vectors[9]  = '{1'b1, 3, 1, 16'd17, 1'b1};
      vectors[10] = '{1'b1, 3, 2, 16'd10, 1'b1};
      vectors[11] = '{1'b1, 3, 3, 16'd3, 1'b1};
      vectors[12] = '{1'b1, 3, 4, 16'd0, 1'b0};
      vectors[13] = '{1'b1, 3, 7, 16'd0, 1'b0};
      vectors[14] = '{1'b1, 14, 7, 16'd63, 1'b1};
      vectors[15] = '{1'b1, 9, 2, 16'd58, 1'b1};

      mWritten = '0; mReady = 1'b0; mRun = 1'b0; mDonePend = 1'b0;
      expOut = '0; expValid = '0; expBusy = 1'b0; expDone = 1'b0; expErr = 1'b0;

      // Reset, then START with nothing loaded
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("resetValid", edgeValid, 0);
      checkVal("resetReady", ready, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      checkVal("errNoLoad", err, 1);
      checkVal("busyNoLoad", busy, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkVal("errOnePulse", err, 0);

      // Row mode then column mode over tile[r][c] = 8r+c
      loadTile(N * N);
      runStream(0, -1, 0, 0, latency);
      checkVal("latencyRow", latency, 16);
      loadTile(N * N);
      runStream(1, -1, 0, 0, latency);
      checkVal("latencyCol", latency, 16);
      for (int v = 0; v < 16; v++) begin
         checkVal($sformatf("vecData%0d", v),
                  obsOut[vectors[v].cm][vectors[v].step][vectors[v].lane], vectors[v].expData);
         checkVal($sformatf("vecValid%0d", v),
                  obsValid[vectors[v].cm][vectors[v].step][vectors[v].lane], vectors[v].expValid);
      end

      // Three held cycles at step 5
      loadTile(N * N);
      runStream(0, 5, 3, 0, latency);
      checkVal("latencyHeld", latency, 19);

      // Writes and STARTs during RUN are ignored; partial reload keeps READY low
      loadTile(N * N);
      runStream(0, -1, 0, 1, latency);
      checkVal("latencyNoise", latency, 16);
      checkVal("lane0Unchanged", obsOut[0][0][0], 0);
      checkVal("readyAfterDone", ready, 0);
      loadTile(N * N - 1);
      checkVal("readyAfter63", ready, 0);
      applyStimulus(1, 1, AW'(N * N - 1), 16'h1234, 0, 0, 0);
      checkVal("readyAfter64", ready, 1);

      // Reset at step 6
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      for (int s = 0; s < 6; s++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("midResetBusy", busy, 0);
      checkVal("midResetReady", ready, 0);
      checkVal("midResetValid", edgeValid, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      checkVal("midResetErr", err, 1);

      // Random traffic, mostly sequential addresses so tiles fill
      begin
         int seqAddr = 0;
         logic [AW-1:0] a;
         for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) < 8) begin
               a = AW'(seqAddr);
               seqAddr = (seqAddr + 1) % (N * N);
            end else begin
               a = AW'($urandom_range(0, N * N - 1));
            end
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 9) < 7), a, DW'($urandom),
                          ($urandom_range(0, 9) == 0), 1'($urandom),
                          ($urandom_range(0, 9) < 3));
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
